// File: rtl/pmem_pkg.sv
// Shared definitions for the physical-memory line port: word/line geometry,
// the burst responder state encoding and the word type.
package pmem_pkg;

    localparam int WORD_W    = 32;
    localparam int LINE_W    = 256;
    localparam int BURST_LEN = 8;
    localparam int BE_W      = WORD_W / 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        BURST = 2'd2,
        DONE  = 2'd3
    } pmem_state_e;

    typedef logic [WORD_W-1:0] word_t;

endpackage

// File: rtl/pmem_word_ram.sv
// Single-port word RAM with synchronous read and per-byte write lanes.
// The read register returns zero whenever no read is issued.
module pmem_word_ram
    import pmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 4096,
    parameter int AW          = $clog2(DEPTH_WORDS)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            rd_en,
    input  logic            wr_en,
    input  logic [AW-1:0]   addr,
    input  word_t           wdata,
    input  logic [BE_W-1:0] byte_en,
    output word_t           rdata
);

    word_t mem_r [DEPTH_WORDS];
    word_t rdata_r;

    // Byte-lane writes; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < BE_W; b++) begin
                if (byte_en[b]) begin
                    mem_r[addr][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

    // Registered read port, zero when idle so it can drive the bus directly.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_r <= 32'h0000_0000;
        end else if (rd_en) begin
            rdata_r <= mem_r[addr];
        end else begin
            rdata_r <= 32'h0000_0000;
        end
    end

    assign rdata = rdata_r;

endmodule

// File: rtl/pmem_burst_responder.sv
// Memory-side responder: accepts a line read/write and moves it as 8 word
// beats after a fixed latency, backed by pmem_word_ram.
module pmem_burst_responder
    import pmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 4096,
    parameter int LATENCY     = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [31:0] mem_address,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_byte_enable,
    output logic        mem_resp,
    output logic [31:0] mem_rdata,
    output logic        proto_err
);

    localparam int         AW        = $clog2(DEPTH_WORDS);
    localparam int         LW        = AW - 3;
    localparam logic [3:0] LAT_LAST  = 4'(LATENCY - 1);
    localparam logic [2:0] BEAT_LAST = 3'(BURST_LEN - 1);

    pmem_state_e   state_r;
    logic          op_write_r;
    logic [LW-1:0] line_idx_r;
    logic [2:0]    beat_r;
    logic [3:0]    lat_r;
    logic          mem_resp_r;
    logic          proto_err_r;

    logic          rd_en_s;
    logic          wr_en_s;
    logic [2:0]    ram_beat_s;
    logic          drop_s;
    logic          unused_addr_s;

    assign unused_addr_s = ^{mem_address[31:AW+2], mem_address[4:0]};

    // Request-drop detection against the latched operation.
    always_comb begin
        drop_s = 1'b0;
        if (op_write_r) begin
            drop_s = ~mem_write;
        end else begin
            drop_s = ~mem_read;
        end
    end

    // RAM control: reads run one beat ahead so data lines up with mem_resp.
    always_comb begin
        rd_en_s    = 1'b0;
        wr_en_s    = 1'b0;
        ram_beat_s = 3'd0;
        case (state_r)
            WAIT: begin
                rd_en_s    = ~op_write_r & (lat_r == LAT_LAST);
                ram_beat_s = 3'd0;
            end
            BURST: begin
                if (op_write_r) begin
                    wr_en_s    = ~rst;
                    ram_beat_s = beat_r;
                end else begin
                    rd_en_s    = (beat_r != BEAT_LAST);
                    ram_beat_s = beat_r + 3'd1;
                end
            end
            default: begin
                rd_en_s    = 1'b0;
                wr_en_s    = 1'b0;
                ram_beat_s = 3'd0;
            end
        endcase
    end

    // Transaction FSM with latency/beat counters and the sticky error flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            op_write_r  <= 1'b0;
            line_idx_r  <= '0;
            beat_r      <= 3'd0;
            lat_r       <= 4'd0;
            mem_resp_r  <= 1'b0;
            proto_err_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (mem_read | mem_write) begin
                        op_write_r <= ~mem_read;
                        line_idx_r <= mem_address[AW+1:5];
                        beat_r     <= 3'd0;
                        lat_r      <= 4'd0;
                        state_r    <= WAIT;
                        if (mem_read & mem_write) begin
                            proto_err_r <= 1'b1;
                        end
                    end
                end
                WAIT: begin
                    if (drop_s) begin
                        proto_err_r <= 1'b1;
                    end
                    if (lat_r == LAT_LAST) begin
                        state_r    <= BURST;
                        mem_resp_r <= 1'b1;
                    end else begin
                        lat_r <= lat_r + 4'd1;
                    end
                end
                BURST: begin
                    if (drop_s) begin
                        proto_err_r <= 1'b1;
                    end
                    if (beat_r == BEAT_LAST) begin
                        state_r    <= DONE;
                        mem_resp_r <= 1'b0;
                        beat_r     <= 3'd0;
                    end else begin
                        beat_r <= beat_r + 3'd1;
                    end
                end
                DONE: begin
                    state_r <= IDLE;
                end
                default: begin
                    state_r    <= IDLE;
                    mem_resp_r <= 1'b0;
                end
            endcase
        end
    end

    pmem_word_ram #(
        .DEPTH_WORDS(DEPTH_WORDS),
        .AW         (AW)
    ) u_ram (
        .clk    (clk),
        .rst    (rst),
        .rd_en  (rd_en_s),
        .wr_en  (wr_en_s),
        .addr   ({line_idx_r, ram_beat_s}),
        .wdata  (mem_wdata),
        .byte_en(mem_byte_enable),
        .rdata  (mem_rdata)
    );

    assign mem_resp  = mem_resp_r;
    assign proto_err = proto_err_r;

endmodule

// File: tb/tb_pmem_burst_responder.sv
// Randomized bench for pmem_burst_responder against a word-array memory model
// that tracks line transfers, byte enables, wrap, errors and reset aborts.
module tb_pmem_burst_responder;

    localparam int DEPTH = 16;
    localparam int LAT   = 4;

    logic        clk;
    logic        rst;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_address;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_byte_enable;
    logic        mem_resp;
    logic [31:0] mem_rdata;
    logic        proto_err;

    logic [31:0] model_mem [DEPTH];
    logic        exp_err;
    int          n_checks;
    int          n_errors;

    pmem_burst_responder #(
        .DEPTH_WORDS(DEPTH),
        .LATENCY    (LAT)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .mem_read       (mem_read),
        .mem_write      (mem_write),
        .mem_address    (mem_address),
        .mem_wdata      (mem_wdata),
        .mem_byte_enable(mem_byte_enable),
        .mem_resp       (mem_resp),
        .mem_rdata      (mem_rdata),
        .proto_err      (proto_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int word_idx(input logic [31:0] addr, input int k);
        return int'((((addr >> 5) * 32'd8) + 32'(k)) % 32'(DEPTH));
    endfunction

    // One line transaction. Called at a negedge with the DUT idle.
    // data_rand: random beat data, else data_base (+k when data_inc).
    // be_rand:   random byte enables, else be_val.
    task automatic run_txn(input bit rd, input bit wr, input logic [31:0] addr,
                           input bit data_rand, input logic [31:0] data_base, input bit data_inc,
                           input bit be_rand, input logic [3:0] be_val,
                           input int drop_beat, input int rst_beat);
        bit          is_read;
        int          w;
        logic [31:0] d;
        logic [3:0]  be;
        is_read     = rd;
        mem_read    = rd;
        mem_write   = wr;
        mem_address = addr;
        if (rd && wr) exp_err = 1'b1;
        @(negedge clk);
        for (int c = 0; c <= LAT + 8; c++) begin
            if (c < LAT) begin
                check_eq("wait_resp", {31'd0, mem_resp}, 32'd0);
            end else if (c < LAT + 8) begin
                w = word_idx(addr, c - LAT);
                check_eq("beat_resp", {31'd0, mem_resp}, 32'd1);
                if (is_read) begin
                    check_eq("read_data", mem_rdata, model_mem[w]);
                end else begin
                    check_eq("write_rdata_zero", mem_rdata, 32'd0);
                end
                if (c - LAT == drop_beat) begin
                    mem_read  = 1'b0;
                    mem_write = 1'b0;
                    exp_err   = 1'b1;
                end
                if (!is_read) begin
                    d  = data_rand ? $urandom : (data_base + (data_inc ? 32'(c - LAT) : 32'd0));
                    be = be_rand ? 4'($urandom_range(15, 0)) : be_val;
                    mem_wdata       = d;
                    mem_byte_enable = be;
                    if (c - LAT != rst_beat) begin
                        for (int b = 0; b < 4; b++) begin
                            if (be[b]) model_mem[w][8*b +: 8] = d[8*b +: 8];
                        end
                    end
                end
                if (c - LAT == rst_beat) begin
                    rst = 1'b1;
                    @(negedge clk);
                    check_eq("rst_abort_resp", {31'd0, mem_resp}, 32'd0);
                    check_eq("rst_abort_rdata", mem_rdata, 32'd0);
                    check_eq("rst_abort_err", {31'd0, proto_err}, 32'd0);
                    exp_err   = 1'b0;
                    rst       = 1'b0;
                    mem_read  = 1'b0;
                    mem_write = 1'b0;
                    return;
                end
            end else begin
                check_eq("done_resp", {31'd0, mem_resp}, 32'd0);
                check_eq("done_rdata", mem_rdata, 32'd0);
                check_eq("proto_err", {31'd0, proto_err}, {31'd0, exp_err});
                mem_read  = 1'b0;
                mem_write = 1'b0;
            end
            @(negedge clk);
        end
    endtask

    initial begin
        n_checks        = 0;
        n_errors        = 0;
        exp_err         = 1'b0;
        rst             = 1'b1;
        mem_read        = 1'b1;
        mem_write       = 1'b0;
        mem_address     = 32'h0000_0040;
        mem_wdata       = 32'd0;
        mem_byte_enable = 4'h0;

        // Reset held with a pending read request.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq("reset_resp", {31'd0, mem_resp}, 32'd0);
            check_eq("reset_rdata", mem_rdata, 32'd0);
            check_eq("reset_err", {31'd0, proto_err}, 32'd0);
        end
        rst      = 1'b0;
        mem_read = 1'b0;
        @(negedge clk);

        // Fill both lines of the small RAM so every model word is known.
        run_txn(1'b0, 1'b1, 32'h0000_0000, 1'b1, 32'd0, 1'b0, 1'b0, 4'hF, -1, -1);
        run_txn(1'b0, 1'b1, 32'h0000_0020, 1'b1, 32'd0, 1'b0, 1'b0, 4'hF, -1, -1);

        // Line write then read.
        run_txn(1'b0, 1'b1, 32'h0000_0040, 1'b0, 32'h1000_0000, 1'b1, 1'b0, 4'hF, -1, -1);
        run_txn(1'b1, 1'b0, 32'h0000_0040, 1'b0, 32'd0, 1'b0, 1'b0, 4'h0, -1, -1);

        // Byte enables over an all-ones line.
        run_txn(1'b0, 1'b1, 32'h0000_0040, 1'b0, 32'hFFFF_FFFF, 1'b0, 1'b0, 4'hF, -1, -1);
        run_txn(1'b0, 1'b1, 32'h0000_0040, 1'b0, 32'h1122_3344, 1'b0, 1'b0, 4'b0101, -1, -1);
        run_txn(1'b1, 1'b0, 32'h0000_0040, 1'b0, 32'd0, 1'b0, 1'b0, 4'h0, -1, -1);

        // Unaligned address and modulo-depth wrap.
        run_txn(1'b1, 1'b0, 32'h0000_005F, 1'b0, 32'd0, 1'b0, 1'b0, 4'h0, -1, -1);
        run_txn(1'b1, 1'b0, 32'h0000_0060, 1'b0, 32'd0, 1'b0, 1'b0, 4'h0, -1, -1);

        // Protocol errors: both requests high, then a read dropped at beat 3.
        run_txn(1'b1, 1'b1, 32'h0000_0020, 1'b1, 32'd0, 1'b0, 1'b0, 4'hF, -1, -1);
        run_txn(1'b1, 1'b0, 32'h0000_0000, 1'b0, 32'd0, 1'b0, 1'b0, 4'h0, 3, -1);
        run_txn(1'b1, 1'b0, 32'h0000_0020, 1'b0, 32'd0, 1'b0, 1'b0, 4'h0, -1, -1);

        // Reset in beat 4 of a write; readback shows old data from beat 4 on.
        run_txn(1'b0, 1'b1, 32'h0000_0080, 1'b1, 32'd0, 1'b0, 1'b0, 4'hF, -1, -1);
        run_txn(1'b0, 1'b1, 32'h0000_0080, 1'b0, 32'hA5A5_A5A0, 1'b1, 1'b0, 4'hF, -1, 4);
        @(negedge clk);
        run_txn(1'b1, 1'b0, 32'h0000_0080, 1'b0, 32'd0, 1'b0, 1'b0, 4'h0, -1, -1);

        // Random traffic.
        for (int i = 0; i < 24; i++) begin
            if ($urandom_range(1, 0) == 0) begin
                run_txn(1'b1, 1'b0, $urandom, 1'b0, 32'd0, 1'b0, 1'b0, 4'h0, -1, -1);
            end else begin
                run_txn(1'b0, 1'b1, $urandom, 1'b1, 32'd0, 1'b0, 1'b1, 4'h0, -1, -1);
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
